// File: rtl/lsu_mem_master.sv
// Load/store initiator for a single-port synchronous DataMemory plus an IO write window.
// It checks alignment, performs read-modify-write for sub-word stores and sign/zero-extends loads.
module lsu_mem_master #(
  parameter int          MEM_AW = 14,
  parameter logic [21:0] IO_HI  = 22'h3FFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              io_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic              accept_s, misalign_s, io_s, wr_io_s, wr_mem_s;
  logic [31:0]       store_word_s;
  logic [MEM_AW-1:0] access_addr_s;

  logic              req_ready_r, resp_valid_r, resp_err_r, mem_write_r, io_write_r;
  logic [31:0]       resp_rdata_r, mem_wdata_r;
  logic [MEM_AW-1:0] mem_addr_r;
  logic [1:0]        lane_r, size_r;
  logic              signed_r, write_r;
  logic [15:0]       wdata_r;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic bad;
    case (sz)
      2'd0:    bad = 1'b0;
      2'd1:    bad = lo[0];
      2'd2:    bad = (lo != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] zext_store(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {24'd0, d[7:0]};
      2'd1:    r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    case (sz)
      2'd0: r[{lane, 3'b000} +: 8] = d[7:0];
      2'd1: begin
        if (lane[1]) begin
          r[31:16] = d;
        end else begin
          r[15:0] = d;
        end
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Next-state decode and request classification
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    misalign_s = is_misaligned(req_size, req_addr[1:0]);
    io_s       = (req_addr[31:10] == IO_HI);
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (misalign_s) begin
            state_s = ST_DONE;
          end else if (!req_write) begin
            state_s = ST_READ;
          end else if (io_s || (req_size == 2'd2)) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ:    state_s = ST_CAPTURE;
      ST_CAPTURE: begin
        if (write_r) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_WRITE:   state_s = ST_DONE;
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Access address, direct store data and write-strobe selection
  always_comb begin
    store_word_s = zext_store(req_size, req_wdata);
    // IO stores address words inside the 1 KiB window, not DataMemory
    if (io_s && req_write) begin
      access_addr_s = {{(MEM_AW-8){1'b0}}, req_addr[9:2]};
    end else begin
      access_addr_s = req_addr[MEM_AW+1:2];
    end
    wr_io_s  = (state_s == ST_WRITE) && accept_s && io_s;
    wr_mem_s = (state_s == ST_WRITE) && !wr_io_s;
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      mem_addr_r   <= {MEM_AW{1'b0}};
      mem_wdata_r  <= 32'd0;
      mem_write_r  <= 1'b0;
      io_write_r   <= 1'b0;
      lane_r       <= 2'd0;
      size_r       <= 2'd0;
      signed_r     <= 1'b0;
      write_r      <= 1'b0;
      wdata_r      <= 16'd0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_DONE);
      mem_write_r  <= wr_mem_s;
      io_write_r   <= wr_io_s;
      if (accept_s) begin
        lane_r     <= req_addr[1:0];
        size_r     <= req_size;
        signed_r   <= req_signed;
        write_r    <= req_write;
        wdata_r    <= req_wdata[15:0];
        resp_err_r <= misalign_s;
        if (!misalign_s) begin
          mem_addr_r <= access_addr_s;
        end
        if (state_s == ST_WRITE) begin
          mem_wdata_r <= store_word_s;
        end
      end else if (state_r == ST_CAPTURE) begin
        if (write_r) begin
          mem_wdata_r <= merge_lane(mem_rdata, size_r, lane_r, wdata_r);
        end else begin
          resp_rdata_r <= load_extend(mem_rdata, size_r, lane_r, signed_r);
        end
      end else if (state_r == ST_DONE) begin
        resp_err_r   <= 1'b0;
        resp_rdata_r <= 32'd0;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  // Reset masks the strobes on the very edge it is applied
  assign mem_write  = mem_write_r & ~rst;
  assign io_write   = io_write_r & ~rst;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a behavioural DataMemory, a reference model
// computing expected responses/writes with plain arithmetic, and a decoupled monitor.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write, io_write;
  logic [31:0] mem_rdata = 32'd0;

  lsu_mem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .io_write(io_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DataMemory: registered read, write on strobe
  logic [31:0] dmem    [0:16383];
  logic [31:0] ref_mem [0:16383];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  typedef struct { logic err; logic [31:0] rdata; int lat; int acc; } resp_t;
  typedef struct { logic io; logic [13:0] addr; logic [31:0] data; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUT responds or strobes a write
  always @(negedge clk) begin : monitor
    resp_t r;
    wr_t   w;
    if (resp_valid) begin
      if (rq.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        r = rq.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_latency", 32'(cyc - r.acc + 1), 32'(r.lat));
      end
    end
    if (mem_write || io_write) begin
      if (wq.size() == 0) begin
        chk("write_unexpected", {30'd0, mem_write, io_write}, 32'd0);
      end else begin
        w = wq.pop_front();
        chk("write_kind", {30'd0, mem_write, io_write}, {30'd0, !w.io, w.io});
        chk("write_addr", {18'd0, mem_addr}, {18'd0, w.addr});
        chk("write_data", mem_wdata, w.data);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, output int acc);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    acc        = cyc;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_write  = 1'($urandom_range(0, 1));
  endtask

  // Reference model: expected response and memory effect of one request
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    resp_t e;
    wr_t w;
    bit has_wr, ok;
    logic [31:0] old, v, mask;
    int unsigned off, idx, nb;
    int acc;
    off = a % 4;
    idx = (a / 4) % 16384;
    has_wr = 1'b0;
    w.io = 1'b0; w.addr = 14'd0; w.data = 32'd0;
    e.err = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    e.rdata = 32'd0;
    e.acc = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (!wr) begin
      old = ref_mem[idx];
      if (sz == 2'd2) begin
        v = old;
      end else begin
        nb = (sz == 2'd0) ? 8 : 16;
        v = (old >> (off * 8)) & ((32'd1 << nb) - 32'd1);
        if (sg && v >= (32'd1 << (nb - 1))) v = v - (32'd1 << nb);
      end
      e.rdata = v;
      e.lat = 3;
    end else if (a[31:10] == 22'h3FFFFF) begin
      has_wr = 1'b1;
      w.io = 1'b1;
      w.addr = 14'((a % 1024) / 4);
      w.data = (sz == 2'd2) ? d : (d & ((sz == 2'd0) ? 32'hFF : 32'hFFFF));
      e.lat = 2;
    end else begin
      old = ref_mem[idx];
      if (sz == 2'd2) begin
        v = d;
        e.lat = 2;
      end else begin
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (off * 8);
        v = (old & ~mask) | ((d << (off * 8)) & mask);
        e.lat = 4;
      end
      ref_mem[idx] = v;
      has_wr = 1'b1;
      w.addr = 14'(idx);
      w.data = v;
    end
    wait_ready(ok);
    if (ok) begin
      drive(wr, sz, sg, a, d, acc);
      e.acc = acc;
      rq.push_back(e);
      if (has_wr) wq.push_back(w);
    end
  endtask

  initial begin
    bit ok;
    int acc;
    logic [31:0] a;
    logic [1:0] sz, lane;
    logic wr;
    for (int i = 0; i < 16384; i++) begin
      dmem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    for (int i = 0; i < 16; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end

    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_err", {31'd0, resp_err}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_strobes", {30'd0, mem_write, io_write}, 32'd0);
    chk("reset_mem_addr", {18'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed scenarios
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11A23344);
    issue(1'b0, 2'd0, 1'b1, 32'h12, 32'd0);
    issue(1'b0, 2'd0, 1'b0, 32'h12, 32'd0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678);
    issue(1'b1, 2'd2, 1'b0, 32'hFFFFFC60, 32'h5);
    issue(1'b0, 2'd2, 1'b0, 32'h0001_0010, 32'd0);

    // Reset during the WRITE cycle of a sub-word store: nothing may land
    wait_ready(ok);
    if (ok) begin
      drive(1'b1, 2'd0, 1'b0, 32'h15, 32'hAA, acc);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_write_masked", {30'd0, mem_write, io_write}, 32'd0);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready_after", {31'd0, req_ready}, 32'd1);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) lane = 2'($urandom_range(0, 3));
      else if (sz == 2'd0) lane = 2'($urandom_range(0, 3));
      else if (sz == 2'd1) lane = {1'($urandom_range(0, 1)), 1'b0};
      else lane = 2'd0;
      if (wr && $urandom_range(0, 4) == 0)
        a = 32'hFFFFFC00 | ($urandom_range(0, 255) << 2) | {30'd0, lane};
      else
        a = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 15) << 2) | {30'd0, lane};
      issue(wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (10) @(negedge clk);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    for (int i = 0; i < 16; i++) chk("final_mem_word", dmem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
